// File: rtl/pc_seq_unit.sv
// pc_seq_unit: architectural PC, fall-through/next-PC select and commit status FSM.
// Define PC_RAS_EN to add a circular return-address stack and the ras_mismatch output.
module pc_seq_unit #(
    parameter int                  DATA_WID  = 64,
    parameter int                  IMM_BYTES = 8,
    parameter logic [DATA_WID-1:0] RESET_VEC = '0,
    parameter int                  CNT_WID   = 32,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                commit,
    input  logic [3:0]          icode,
    input  logic                Cnd,
    input  logic [DATA_WID-1:0] valC,
    input  logic [DATA_WID-1:0] valM,
    output logic [DATA_WID-1:0] PC,
    output logic [DATA_WID-1:0] valP,
    output logic [1:0]          stat,
    output logic [CNT_WID-1:0]  retired
`ifdef PC_RAS_EN
    ,
    output logic                ras_mismatch
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        INS  = 2'b10
    } stat_e;

    stat_e               state_q, state_n;
    logic [DATA_WID-1:0] pc_q, pc_n;
    logic [DATA_WID-1:0] len, npc, ret_pc;
    logic [CNT_WID-1:0]  ret_q, ret_n;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two, at least 2");
    end

    always_comb begin
        len = DATA_WID'(1);
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: len = DATA_WID'(2);
            4'h3, 4'h4, 4'h5:       len = DATA_WID'(2 + IMM_BYTES);
            4'h7, 4'h8:             len = DATA_WID'(1 + IMM_BYTES);
            default:                len = DATA_WID'(1);
        endcase
    end

    assign valP = pc_q + len;

    always_comb begin
        case (icode)
            4'h7:    npc = Cnd ? valC : valP;
            4'h8:    npc = valC;
            4'h9:    npc = ret_pc;
            default: npc = valP;
        endcase
    end

    // halt retires but leaves PC pointing at itself
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        ret_n   = ret_q;
        if (state_q == RUN && commit) begin
            if (icode[3] && icode[2]) begin
                state_n = INS;
            end else begin
                ret_n = ret_q + CNT_WID'(1);
                if (icode == 4'h0) state_n = HALT;
                else               pc_n    = npc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
            ret_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            ret_q   <= ret_n;
        end
    end

    assign PC      = pc_q;
    assign stat    = state_q;
    assign retired = ret_q;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [DATA_WID-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]       ras_ptr, top_idx;
    logic [PW:0]         ras_cnt;
    logic                go, push, pop, ras_hit, mis_q;

    assign go      = state_q == RUN && commit && !(icode[3] && icode[2]);
    assign push    = go && icode == 4'h8;
    assign pop     = go && icode == 4'h9;
    assign top_idx = ras_ptr - PW'(1);
    assign ras_hit = ras_cnt != '0;
    assign ret_pc  = ras_hit ? ras_mem[top_idx] : valM;

    // a full stack keeps the count and lets the write pointer clobber the oldest
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            mis_q   <= 1'b0;
        end else begin
            mis_q <= pop && ras_hit && (ras_mem[top_idx] != valM);
            if (push) begin
                ras_ptr <= ras_ptr + PW'(1);
                if (ras_cnt != (PW+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (PW+1)'(1);
            end else if (pop && ras_hit) begin
                ras_ptr <= top_idx;
                ras_cnt <= ras_cnt - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) ras_mem[ras_ptr] <= valP;
    end

    assign ras_mismatch = mis_q;
`else
    assign ret_pc = valM;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed literal checks plus randomized run against a behavioural model.
// Honours PC_RAS_EN the same way the design does.
module tb_pc_seq_unit;

    localparam int DW = 64;
    localparam int IB = 8;
    localparam int CW = 32;
    localparam int RD = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          commit = 1'b0;
    logic [3:0]    icode = 4'h1;
    logic          Cnd = 1'b0;
    logic [DW-1:0] valC = '0;
    logic [DW-1:0] valM = '0;
    wire  [DW-1:0] PC, valP;
    wire  [1:0]    stat;
    wire  [CW-1:0] retired;
`ifdef PC_RAS_EN
    wire           ras_mismatch;
`endif

    pc_seq_unit #(
        .DATA_WID(DW), .IMM_BYTES(IB), .RESET_VEC(64'h0),
        .CNT_WID(CW), .RAS_DEPTH(RD)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .commit(commit), .icode(icode),
        .Cnd(Cnd), .valC(valC), .valM(valM),
        .PC(PC), .valP(valP), .stat(stat), .retired(retired)
`ifdef PC_RAS_EN
        , .ras_mismatch(ras_mismatch)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] m_pc = '0;
    logic [1:0]    m_stat = 2'd0;
    logic [CW-1:0] m_ret = '0;
    logic          m_mis = 1'b0;
    logic [DW-1:0] m_ras [$];
    logic [DW-1:0] last_ret = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 2 + IB;
            4'h7, 4'h8:             return 1 + IB;
            default:                return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = '0;
        m_stat = 2'd0;
        m_ret = '0;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic [DW-1:0] vp, t;
        m_mis = 1'b0;
        if (m_stat == 2'd0 && commit) begin
            if (icode >= 4'hC) begin
                m_stat = 2'd2;
            end else begin
                vp = m_pc + ilen(icode);
                m_ret = m_ret + 1;
                case (icode)
                    4'h0: m_stat = 2'd1;
                    4'h7: m_pc = Cnd ? valC : vp;
                    4'h8: begin
`ifdef PC_RAS_EN
                        m_ras.push_back(vp);
                        if (m_ras.size() > RD) void'(m_ras.pop_front());
`endif
                        m_pc = valC;
                    end
                    4'h9: begin
                        m_pc = valM;
`ifdef PC_RAS_EN
                        if (m_ras.size() > 0) begin
                            t = m_ras.pop_back();
                            m_pc = t;
                            m_mis = (t != valM);
                        end
`endif
                    end
                    default: m_pc = vp;
                endcase
            end
        end
    endtask

    // Every negedge: DUT state against the model
    always @(negedge CLK) begin
        chk("pc", PC, m_pc);
        chk("valp", valP, m_pc + ilen(icode));
        chk("stat", {62'd0, stat}, {62'd0, m_stat});
        chk("retired", {32'd0, retired}, {32'd0, m_ret});
`ifdef PC_RAS_EN
        chk("ras_mismatch", {63'd0, ras_mismatch}, {63'd0, m_mis});
`endif
    end

    task automatic tick();
        @(posedge CLK);
        if (RST_N) model_step();
        #1;
    endtask

    task automatic do_reset(input bit lit);
        #1;
        RST_N = 1'b0;
        model_reset();
        #1;
        if (lit) begin
            chk("rst_pc", PC, 64'h0);
            chk("rst_stat", {62'd0, stat}, 64'd0);
            chk("rst_retired", {32'd0, retired}, 64'd0);
        end
        RST_N = 1'b1;
    endtask

    task automatic op(input logic [3:0] ic, input logic c,
                      input logic [DW-1:0] vc, input logic [DW-1:0] vm);
        icode = ic;
        Cnd = c;
        valC = vc;
        valM = vm;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        icode = 4'h1;
    endtask

    task automatic go_to(input logic [DW-1:0] a);
        op(4'h7, 1'b1, a, '0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("init_pc", PC, 64'h0);
        chk("init_stat", {62'd0, stat}, 64'd0);
        chk("init_retired", {32'd0, retired}, 64'd0);
        RST_N = 1'b1;
        repeat (3) tick();
        chk("hold_pc", PC, 64'h0);
        chk("hold_retired", {32'd0, retired}, 64'd0);

        op(4'h6, 1'b0, '0, '0);
        chk("seq1_pc", PC, 64'd2);
        chk("seq1_ret", {32'd0, retired}, 64'd1);
        op(4'h3, 1'b0, '0, '0);
        chk("seq2_pc", PC, 64'd12);
        chk("seq2_ret", {32'd0, retired}, 64'd2);
        go_to(64'hFFFF_FFFF_FFFF_FFFE);
        icode = 4'h3;
        #1;
        chk("wrap_valp", valP, 64'd8);
        op(4'h3, 1'b0, '0, '0);
        chk("wrap_pc", PC, 64'd8);

        go_to(64'h20);
        op(4'h7, 1'b0, 64'h100, '0);
        chk("jxx_nt", PC, 64'h29);
        go_to(64'h20);
        op(4'h7, 1'b1, 64'h100, '0);
        chk("jxx_t", PC, 64'h100);

        go_to(64'h10);
        op(4'h8, 1'b0, 64'h200, '0);
        chk("call_pc", PC, 64'h200);
        op(4'h9, 1'b0, '0, 64'h19);
        chk("ret_pc", PC, 64'h19);
`ifdef PC_RAS_EN
        chk("ret_mis0", {63'd0, ras_mismatch}, 64'd0);
`endif
        go_to(64'h10);
        op(4'h8, 1'b0, 64'h200, '0);
        op(4'h9, 1'b0, '0, 64'h40);
`ifdef PC_RAS_EN
        chk("ret_ras_pc", PC, 64'h19);
        chk("ret_mis1", {63'd0, ras_mismatch}, 64'd1);
        tick();
        chk("ret_mis_clr", {63'd0, ras_mismatch}, 64'd0);
`else
        chk("ret_valm_pc", PC, 64'h40);
`endif

        do_reset(1'b1);
        go_to(64'h30);
        op(4'h0, 1'b0, '0, '0);
        chk("halt_stat", {62'd0, stat}, 64'd1);
        chk("halt_pc", PC, 64'h30);
        chk("halt_ret", {32'd0, retired}, 64'd2);
        op(4'h6, 1'b0, '0, '0);
        op(4'h7, 1'b1, 64'h500, '0);
        chk("halt_frz_pc", PC, 64'h30);
        chk("halt_frz_ret", {32'd0, retired}, 64'd2);
        do_reset(1'b1);

        go_to(64'h44);
        op(4'hC, 1'b0, '0, '0);
        chk("ins_stat", {62'd0, stat}, 64'd2);
        chk("ins_pc", PC, 64'h44);
        chk("ins_ret", {32'd0, retired}, 64'd1);
        op(4'h6, 1'b0, '0, '0);
        chk("ins_frz_pc", PC, 64'h44);
        chk("ins_frz_stat", {62'd0, stat}, 64'd2);
        do_reset(1'b1);

        go_to(64'h1000);
        for (int k = 1; k <= 5; k++)
            op(4'h8, 1'b0, 64'(k + 1) << 12, '0);
        for (int k = 5; k >= 1; k--) begin
            op(4'h9, 1'b0, '0, (64'(k) << 12) + 64'h9);
            chk("ovf_ret_pc", PC, (64'(k) << 12) + 64'h9);
`ifdef PC_RAS_EN
            chk("ovf_mis", {63'd0, ras_mismatch}, 64'd0);
`endif
        end

        do_reset(1'b0);
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       icode = 4'h0;
            else if (r < 4)  icode = 4'(12 + $urandom_range(0, 3));
            else if (r < 24) icode = 4'h9;
            else if (r < 44) icode = 4'h8;
            else begin
                logic [3:0] pick [9];
                pick = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB};
                icode = pick[$urandom_range(0, 8)];
            end
            commit = ($urandom_range(0, 3) != 0);
            Cnd = 1'($urandom_range(0, 1));
            valC = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) valC = ~64'h0 - 64'($urandom_range(0, 15));
            valM = $urandom_range(0, 1) ? last_ret : {$urandom(), $urandom()};
            if (commit && icode == 4'h8 && m_stat == 2'd0) last_ret = m_pc + ilen(4'h8);
            tick();
            if ((m_stat != 2'd0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                do_reset(1'b0);
        end
        commit = 1'b0;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised successor to the single-cycle Y86 PC update logic.
- Holds the architectural PC and computes the fall-through address (valP) from icode, with instruction lengths generic in immediate size.
- Selects the next PC for jump, call and return.
- Adds a commit handshake, a RUN/HALT/INS status state machine and a wrapping retired-instruction counter.
- Sits between fetch (consumes PC, valP) and the execute/memory stages (supply Cnd, valC, valM).

Parameters:
- DATA_WID, 64, width of PC, valC, valM, valP.
- IMM_BYTES, 8, immediate/displacement size in bytes used in length decode.
- RESET_VEC, 0, PC value loaded on reset.
- CNT_WID, 32, width of the retired-instruction counter.
- RAS_DEPTH, 4, return-address-stack entries; used only with PC_RAS_EN, power of two, at least 2.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- commit  input  1  current instruction completes this cycle; PC may update.
- icode  input  4  instruction code of the instruction at PC.
- Cnd  input  1  branch condition from execute.
- valC  input  DATA_WID  immediate/destination from decode.
- valM  input  DATA_WID  word read from memory (return address on RET).
- PC  output  DATA_WID  current program counter, registered.
- valP  output  DATA_WID  fall-through address, combinational from PC and icode.
- stat  output  2  00 = RUN (AOK), 01 = HALT, 10 = INS (invalid instruction), registered.
- retired  output  CNT_WID  retired-instruction count, registered.
- ras_mismatch  output  1  present only with PC_RAS_EN; see Optional Feature.

Behaviour:
- Reset (RST_N low, asynchronous): PC=RESET_VEC, stat=RUN, retired=0, ras_mismatch=0, RAS empty. Reset asserted mid-run overrides everything immediately.
- Length decode (combinational), with I=IMM_BYTES:
  - 1 byte: icode 0 (halt), 1 (nop), 9 (ret).
  - 2 bytes: icode 2 (rrmov/cmov), 6 (op), A (push), B (pop).
  - 2+I bytes: icode 3 (irmov), 4 (rmmov), 5 (mrmov).
  - 1+I bytes: icode 7 (jxx), 8 (call).
  - 1 byte: icode C–F (invalid).
- valP = PC + length, modulo 2^DATA_WID; wraps silently.
- Next PC: 7 with Cnd=1 → valC; 7 with Cnd=0 → valP; 8 → valC; 9 → valM (or RAS, see below); all other valid codes → valP.
- State RUN with commit=1:
  - icode 0–B: PC ← next PC, retired ← retired+1 (wraps at 2^CNT_WID).
  - icode 0 (halt): additionally stat ← HALT, and PC is NOT updated (stays at the halt instruction).
  - icode C–F: stat ← INS; PC and retired unchanged.
- State RUN with commit=0: all registers hold. valP still tracks the current icode.
- States HALT and INS: terminal. commit is ignored; PC, retired and the RAS are frozen. Only reset exits.
- One update per cycle; latency 1 cycle from a commit edge to the new PC.
- Inputs are sampled only on the commit cycle. No requirement on their stability otherwise.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: adds a RAS_DEPTH-entry circular return-address stack.
  - CALL commit pushes valP. When full, the oldest entry is overwritten.
  - RET commit pops. When non-empty, the next PC is the popped value, not valM. When empty, the next PC is valM.
  - ras_mismatch is a registered 1-cycle pulse when a non-empty pop differs from valM; otherwise 0.
- Not defined: no stack, no ras_mismatch port. RET always uses valM.

Test Plan:
- Reset: hold RST_N=0 → PC=0, stat=00, retired=0; release, commit=0 for 3 cycles → all hold.
- Sequential flow (DATA_WID=64, IMM_BYTES=8): PC=0, icode=6, commit → PC=2, retired=1; icode=3, commit → PC=12, retired=2; PC=2^64−2 with icode=3 → valP=8, PC wraps to 8.
- Branch: at PC=0x20, icode=7, valC=0x100: Cnd=0 → PC=0x29; repeat with Cnd=1 → PC=0x100.
- Call/return: at PC=0x10, icode=8, valC=0x200 → PC=0x200; then icode=9, valM=0x19 → PC=0x19, ras_mismatch=0. With PC_RAS_EN and valM=0x40 → PC=0x19, ras_mismatch=1 for one cycle. Without the macro → PC=0x40.
- Halt/invalid:
  - icode=0, commit → stat=01, PC unchanged, retired incremented.
  - Separately, icode=0xC, commit → stat=10, PC and retired unchanged.
  - Further commits in either state change nothing.
  - Pulse RST_N low mid-cycle → PC=RESET_VEC immediately, stat=00.
- RAS overflow (PC_RAS_EN, RAS_DEPTH=4): 5 nested CALLs then 5 RETs with valM equal to the true return addresses → first 4 RETs match, 5th falls back to valM, ras_mismatch stays 0.
